// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  localparam int unsigned N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_full_subtractor.sv
// 1-bit full subtractor cell: computes a - b - bin.
// Ports: a (minuend bit), b (subtrahend bit), bin (borrow in),
//        d (difference bit), bout (borrow out).
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: recovers Y = Z - X one bit per clock, LSB first,
// and flags err when the difference is negative or does not fit in N bits.
// Ports: clk, rst (sync, active-high), start (accepted in IDLE only),
//        Z (N+1-bit minuend), X (N-bit subtrahend), Y (N-bit result),
//        err (out-of-range flag), busy (high in SHIFT), done (1-cycle pulse).
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N:0]   Z,
  input  logic [N-1:0] X,
  output logic [N-1:0] Y,
  output logic         err,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = $clog2(N + 1);

  state_t        state;
  state_t        state_next;
  logic [N:0]    a_sr;
  logic [N:0]    b_sr;
  logic [N:0]    result;
  logic [N:0]    result_next;
  logic          borrow;
  logic [CW-1:0] cnt;
  logic          diff_bit;
  logic          borrow_out;
  logic          accept;
  logic          last_bit;

  // Single borrow cell, fed from the LSB of both operand shift registers.
  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (diff_bit),
    .bout (borrow_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; SHIFT runs for exactly N+1 edges.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    last_bit    = 1'b0;
    result_next = {diff_bit, result[N:1]};
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(N)) begin
          last_bit   = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      result <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      Y      <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= (state_next == SHIFT);
      done <= (state_next == DONE);
      if (accept) begin
        a_sr   <= Z;
        b_sr   <= {1'b0, X};
        result <= '0;
        borrow <= 1'b0;
        cnt    <= '0;
      end else if (state == SHIFT) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        result <= result_next;
        borrow <= borrow_out;
        cnt    <= cnt + CW'(1);
        // Outputs update only as the last bit lands, so they hold across a later SHIFT.
        if (last_bit) begin
          Y   <= result_next[N-1:0];
          err <= borrow_out | result_next[N];
        end
      end
    end
  end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random
// operands compared against an integer-arithmetic reference.
module tb_serial_subtractor;

  localparam int N    = 4;
  localparam int MASK = (1 << N) - 1;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N:0]   Z;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic         err;
  logic         busy;
  logic         done;

  int checks;
  int errors;

  serial_subtractor #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Z     (Z),
    .X     (X),
    .Y     (Y),
    .err   (err),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_y(input int z, input int x);
    return (z - x) & MASK;
  endfunction

  function automatic int ref_err(input int z, input int x);
    int diff;
    diff = z - x;
    return ((diff < 0) || (diff > MASK)) ? 1 : 0;
  endfunction

  // One operation: start pulse, then scrambled inputs; checks latency, busy width,
  // Y hold during SHIFT, result and single done pulse. poke re-pulses start mid-SHIFT.
  task automatic do_op(input int z, input int x, input bit poke);
    int   cycles;
    int   busy_cnt;
    int   seconds;
    bit   hold_ok;
    logic [N-1:0] prev_y;
    start  = 1'b1;
    Z      = (N+1)'(z);
    X      = N'(x);
    cycles = 0;
    busy_cnt = 0;
    hold_ok = 1'b1;
    prev_y = Y;
    @(negedge clk);
    start = 1'b0;
    Z = (N+1)'($urandom);
    X = N'($urandom);
    cycles = 1;
    if (busy) busy_cnt++;
    while (!done && cycles < 50) begin
      if (Y !== prev_y) hold_ok = 1'b0;
      if (poke && cycles == 2) begin
        start = 1'b1;
        Z = 5'd20;
        X = 4'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    check("done_seen", 32'(done), 32'd1);
    check("latency", 32'(cycles), 32'(N + 2));
    check("busy_cycles", 32'(busy_cnt), 32'(N + 1));
    check("y_hold", 32'(hold_ok), 32'd1);
    check("y", 32'(Y), 32'(ref_y(z, x)));
    check("err", 32'(err), 32'(ref_err(z, x)));
    seconds = 0;
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      if (done) seconds++;
    end
    check("single_done", 32'(seconds), 32'd0);
    check("y_after", 32'(Y), 32'(ref_y(z, x)));
  endtask

  initial begin
    int done_t[$];
    int done_cnt;
    int t;
    checks = 0;
    errors = 0;
    rst   = 1'b1;
    start = 1'b1;
    Z     = '0;
    X     = '0;
    repeat (2) @(negedge clk);
    check("rst_y", 32'(Y), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst   = 1'b0;
    start = 1'b0;

    do_op(11, 8, 1'b0);
    do_op(8, 4, 1'b0);
    do_op(10, 3, 1'b0);
    do_op(7, 2, 1'b0);
    do_op(3, 7, 1'b0);
    do_op(31, 0, 1'b0);
    do_op(15, 15, 1'b0);
    do_op(9, 1, 1'b1);

    // Reset on the third SHIFT cycle aborts the operation.
    start = 1'b1;
    Z = 5'd25;
    X = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_y", 32'(Y), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    do_op(16, 6, 1'b0);

    // Start held high: one result every N+3 cycles.
    start = 1'b1;
    Z = 5'd12;
    X = 4'd5;
    done_cnt = 0;
    for (t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (done) begin
        done_t.push_back(t);
        check("b2b_y", 32'(Y), 32'd7);
        check("b2b_err", 32'(err), 32'd0);
      end
    end
    start = 1'b0;
    done_cnt = done_t.size();
    check("b2b_count", 32'(done_cnt), 32'd5);
    if (done_cnt > 0) check("b2b_first", 32'(done_t[0]), 32'(N + 2));
    for (int i = 1; i < done_cnt; i++)
      check("b2b_spacing", 32'(done_t[i] - done_t[i-1]), 32'(N + 3));
    repeat (N + 4) @(negedge clk);

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 30; i++) begin
      do_op(int'($urandom_range(0, 2 * MASK + 1)), int'($urandom_range(0, MASK)),
            bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_subtractor
